// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between IFU and LSU

module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TMO_W  = 8
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int WM_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    // Owner encoding shared by owner_q and last_grant_q
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam logic [TMO_W-1:0] CNT_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] CNT_MAX = {TMO_W{1'b1}};

    state_t             state_q,      state_d;
    logic               owner_q,      owner_d;
    logic               last_grant_q, last_grant_d;
    logic               wen_q,        wen_d;
    logic [ADDR_W-1:0]  addr_q,       addr_d;
    logic [DATA_W-1:0]  wdata_q,      wdata_d;
    logic [WM_W-1:0]    wmask_q,      wmask_d;
    logic [TMO_W-1:0]   cnt_q,        cnt_d;
    logic [DATA_W-1:0]  rdata_q,      rdata_d;
    logic               err_q,        err_d;

    logic               grant_ifu;
    logic               grant_lsu;
    logic [TMO_W-1:0]   cnt_inc;

    // Grant decision in IDLE: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        grant_ifu = (state_q == S_IDLE) && ifu_req_valid &&
                    (!lsu_req_valid || (last_grant_q == OWN_LSU));
        grant_lsu = (state_q == S_IDLE) && lsu_req_valid && !grant_ifu;
    end

    assign cnt_inc = cnt_q + CNT_ONE;

    // Next-state and datapath: latch command at grant, count wait cycles, capture response or timeout
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_ifu) begin
                    owner_d      = OWN_IFU;
                    last_grant_d = OWN_IFU;
                    wen_d        = 1'b0;
                    addr_d       = ifu_addr;
                    wdata_d      = '0;
                    wmask_d      = '0;
                    state_d      = S_REQ;
                end else if (grant_lsu) begin
                    owner_d      = OWN_LSU;
                    last_grant_d = OWN_LSU;
                    wen_d        = lsu_wen;
                    addr_d       = lsu_addr;
                    wdata_d      = lsu_wdata;
                    wmask_d      = lsu_wmask;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                // Bridge back-pressure may last forever; the watchdog only covers the response
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // A response arriving on the final count still beats the timeout
                if (mem_rsp_valid) begin
                    rdata_d = wen_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_RSP;
                end else if (cnt_inc == CNT_MAX) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; after reset the IFU wins the first tie because the LSU counts as last served
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_LSU;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_wen       = wen_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign ifu_rsp_valid = (state_q == S_RSP) && (owner_q == OWN_IFU);
    assign lsu_rsp_valid = (state_q == S_RSP) && (owner_q == OWN_LSU);
    assign ifu_rdata     = rdata_q;
    assign lsu_rdata     = rdata_q;
    assign ifu_err       = ifu_rsp_valid && err_q;
    assign lsu_err       = lsu_rsp_valid && err_q;

    a_single_grant: assert property (@(posedge clk) disable iff (!rst)
        !(ifu_req_ready && lsu_req_ready));

    a_req_held: assert property (@(posedge clk) disable iff (!rst)
        (mem_req_valid && !mem_req_ready) |=> (mem_req_valid && $stable(mem_addr)
                                               && $stable(mem_wdata) && $stable(mem_wmask)
                                               && $stable(mem_wen)));

endmodule
